// File: rtl/bus_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM bus port arbiter.
package bus_port_arbiter_pkg;

  // Arbiter FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS_IF  = 2'd1,
    ST_BUS_MEM = 2'd2,
    ST_DRAIN   = 2'd3
  } arb_state_e;

  // Wide constants; users slice them down to their own data/select widths.
  localparam logic [1023:0] ZERO_WORD   = '0;
  localparam logic [127:0]  BUS_SEL_ALL = '1;

  // Pipeline-control polarities.
  localparam logic FLUSH        = 1'b1;
  localparam logic STALL_ENABLE = 1'b1;

  // Width of a watchdog counter that must be able to hold the value timeout.
  function automatic int wd_cnt_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/bus_port_arbiter_bus_watchdog.sv
// Saturating cycle counter used to abort bus transactions that never see an ack.
module bus_watchdog
  import bus_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = wd_cnt_width(TIMEOUT);

  logic [CNT_W-1:0] cnt_reg;

  // Count enabled cycles; clear wins over enable; stop at all-ones so it never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Terminal count: the current cycle is the TIMEOUT-th one spent waiting.
  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign tc = 1'b0;
    end else begin : g_enabled
      assign tc = (cnt_reg >= CNT_W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/bus_port_arbiter.sv
// Shares one external memory bus between the fetch (IF) and load/store (MEM) ports.
// MEM wins over IF, one transaction at a time; flushed transactions drain silently.
module bus_port_arbiter
  import bus_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_sel,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_ready,
  output logic                stallreq_from_if,
  output logic                stallreq_from_mem,
  output logic                bus_cyc,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_sel,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack,
  output logic                timeout
);

  localparam int SEL_W = DATA_W / 8;

  arb_state_e state_reg, state_next;

  logic              bus_cyc_next;
  logic              bus_we_next;
  logic [SEL_W-1:0]  bus_sel_next;
  logic [ADDR_W-1:0] bus_addr_next;
  logic [DATA_W-1:0] bus_wdata_next;
  logic [DATA_W-1:0] if_rdata_next;
  logic [DATA_W-1:0] mem_rdata_next;
  logic              if_ready_next;
  logic              mem_ready_next;
  logic              timeout_next;

  logic wd_clr;
  logic wd_en;
  logic wd_tc;

  // A port is still waiting unless its ready is pulsing right now; this keeps the
  // request that is being completed from being granted a second time in IDLE.
  logic if_pending;
  logic mem_pending;

  assign if_pending  = if_req && !if_ready;
  assign mem_pending = mem_req && !mem_ready;

  // Stall requests are combinational and vanish at once while reset is held.
  assign stallreq_from_if  = (rst && if_pending)  ? STALL_ENABLE : !STALL_ENABLE;
  assign stallreq_from_mem = (rst && mem_pending) ? STALL_ENABLE : !STALL_ENABLE;

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk(clk),
    .rst(rst),
    .clr(wd_clr),
    .en (wd_en),
    .tc (wd_tc)
  );

  // State and registered outputs; reset abandons any transaction immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      bus_cyc   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= '0;
      bus_addr  <= '0;
      bus_wdata <= ZERO_WORD[DATA_W-1:0];
      if_rdata  <= ZERO_WORD[DATA_W-1:0];
      mem_rdata <= ZERO_WORD[DATA_W-1:0];
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_reg <= state_next;
      bus_cyc   <= bus_cyc_next;
      bus_we    <= bus_we_next;
      bus_sel   <= bus_sel_next;
      bus_addr  <= bus_addr_next;
      bus_wdata <= bus_wdata_next;
      if_rdata  <= if_rdata_next;
      mem_rdata <= mem_rdata_next;
      if_ready  <= if_ready_next;
      mem_ready <= mem_ready_next;
      timeout   <= timeout_next;
    end
  end

  // Next-state and output decisions: bus fields hold, pulses default low.
  always_comb begin
    state_next     = state_reg;
    bus_cyc_next   = bus_cyc;
    bus_we_next    = bus_we;
    bus_sel_next   = bus_sel;
    bus_addr_next  = bus_addr;
    bus_wdata_next = bus_wdata;
    if_rdata_next  = if_rdata;
    mem_rdata_next = mem_rdata;
    if_ready_next  = 1'b0;
    mem_ready_next = 1'b0;
    timeout_next   = 1'b0;
    wd_clr         = 1'b0;
    wd_en          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (flush != FLUSH) begin
          if (mem_pending) begin
            bus_cyc_next   = 1'b1;
            bus_we_next    = mem_we;
            bus_sel_next   = mem_sel;
            bus_addr_next  = mem_addr;
            bus_wdata_next = mem_wdata;
            wd_clr         = 1'b1;
            state_next     = ST_BUS_MEM;
          end else if (if_pending) begin
            bus_cyc_next   = 1'b1;
            bus_we_next    = 1'b0;
            bus_sel_next   = BUS_SEL_ALL[SEL_W-1:0];
            bus_addr_next  = if_addr;
            bus_wdata_next = ZERO_WORD[DATA_W-1:0];
            wd_clr         = 1'b1;
            state_next     = ST_BUS_IF;
          end
        end
      end

      ST_BUS_IF, ST_BUS_MEM: begin
        wd_en = 1'b1;
        if (bus_ack) begin
          // Completion; a simultaneous flush discards the data and the ready.
          bus_cyc_next = 1'b0;
          state_next   = ST_IDLE;
          if (flush != FLUSH) begin
            if (state_reg == ST_BUS_IF) begin
              if_rdata_next = bus_rdata;
              if_ready_next = 1'b1;
            end else begin
              if (!bus_we) begin
                mem_rdata_next = bus_rdata;
              end
              mem_ready_next = 1'b1;
            end
          end
        end else if (flush == FLUSH) begin
          // The bus cannot be aborted, so wait out the ack in DRAIN.
          state_next = ST_DRAIN;
        end else if (wd_tc) begin
          bus_cyc_next = 1'b0;
          timeout_next = 1'b1;
          state_next   = ST_IDLE;
          if (state_reg == ST_BUS_IF) begin
            if_rdata_next = ZERO_WORD[DATA_W-1:0];
            if_ready_next = 1'b1;
          end else begin
            mem_rdata_next = ZERO_WORD[DATA_W-1:0];
            mem_ready_next = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        wd_en = 1'b1;
        if (bus_ack || wd_tc) begin
          bus_cyc_next = 1'b0;
          timeout_next = !bus_ack;
          state_next   = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_port_arbiter.sv
// Directed bench for bus_port_arbiter with a transaction-level reference model.
module tb_bus_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stallreq_from_if;
  logic        stallreq_from_mem;
  logic        bus_cyc;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  bus_port_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .if_req           (if_req),
    .if_addr          (if_addr),
    .if_rdata         (if_rdata),
    .if_ready         (if_ready),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_sel          (mem_sel),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_ready        (mem_ready),
    .stallreq_from_if (stallreq_from_if),
    .stallreq_from_mem(stallreq_from_mem),
    .bus_cyc          (bus_cyc),
    .bus_we           (bus_we),
    .bus_sel          (bus_sel),
    .bus_addr         (bus_addr),
    .bus_wdata        (bus_wdata),
    .bus_rdata        (bus_rdata),
    .bus_ack          (bus_ack),
    .timeout          (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // One outstanding transaction record; age = cycles it has spent on the bus.
  bit          m_valid;
  bit          m_drop;
  int          m_age;
  int          m_port;   // 1 = IF, 2 = MEM
  bit          m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  bit          e_if_ready, e_mem_ready, e_timeout;
  logic [31:0] e_if_rdata, e_mem_rdata;
  bit          p_if, p_mem;

  task automatic deliver(input logic [31:0] data, input bit keep_for_store);
    if (m_port == 1) begin
      e_if_ready = 1'b1;
      e_if_rdata = data;
    end else begin
      e_mem_ready = 1'b1;
      if (!(keep_for_store && m_we)) e_mem_rdata = data;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid = 0; m_drop = 0; m_age = 0; m_port = 0;
      e_if_ready = 0; e_mem_ready = 0; e_timeout = 0;
      e_if_rdata = '0; e_mem_rdata = '0;
    end else begin
      // A request whose ready is showing this cycle is finished, not new.
      p_if  = if_req && !e_if_ready;
      p_mem = mem_req && !e_mem_ready;
      e_if_ready = 0; e_mem_ready = 0; e_timeout = 0;
      if (m_valid) begin
        m_age++;
        if (bus_ack) begin
          m_valid = 0;
          if (!m_drop && !flush) deliver(bus_rdata, 1'b1);
        end else if (flush && !m_drop) begin
          m_drop = 1;
        end else if (TO != 0 && m_age >= TO) begin
          m_valid   = 0;
          e_timeout = 1;
          if (!m_drop) deliver(32'h0, 1'b0);
        end
      end else if (!flush) begin
        if (p_mem) begin
          m_valid = 1; m_drop = 0; m_age = 0; m_port = 2;
          m_we = mem_we; m_sel = mem_sel; m_addr = mem_addr; m_wdata = mem_wdata;
        end else if (p_if) begin
          m_valid = 1; m_drop = 0; m_age = 0; m_port = 1;
          m_we = 0; m_sel = 4'hF; m_addr = if_addr; m_wdata = '0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    cmp("bus_cyc", 64'(bus_cyc), 64'(m_valid));
    if (m_valid) begin
      cmp("bus_addr", 64'(bus_addr), 64'(m_addr));
      cmp("bus_we", 64'(bus_we), 64'(m_we));
      cmp("bus_sel", 64'(bus_sel), 64'(m_sel));
      if (m_we) cmp("bus_wdata", 64'(bus_wdata), 64'(m_wdata));
    end
    cmp("if_ready", 64'(if_ready), 64'(e_if_ready));
    cmp("mem_ready", 64'(mem_ready), 64'(e_mem_ready));
    cmp("timeout", 64'(timeout), 64'(e_timeout));
    cmp("if_rdata", 64'(if_rdata), 64'(e_if_rdata));
    cmp("mem_rdata", 64'(mem_rdata), 64'(e_mem_rdata));
    cmp("stall_if", 64'(stallreq_from_if), 64'(rst && if_req && !e_if_ready));
    cmp("stall_mem", 64'(stallreq_from_mem), 64'(rst && mem_req && !e_mem_ready));
  end

  // ---------------- directed stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL global time limit: got no end, required finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 0; flush = 0; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
    mem_sel = 0; mem_addr = 0; mem_wdata = 0; bus_rdata = 0; bus_ack = 0;
    next_cycle(); next_cycle();
    look();
    cmp("reset bus_cyc", 64'(bus_cyc), 64'd0);
    cmp("reset bus_addr", 64'(bus_addr), 64'd0);
    cmp("reset if_rdata", 64'(if_rdata), 64'd0);
    next_cycle();
    rst = 1;
    next_cycle();

    // Single fetch, ack in cycle 2.
    if_req = 1; if_addr = 32'h0000_0100;                               // c0
    look(); cmp("t1 c0 stall_if", 64'(stallreq_from_if), 64'd1);
    cmp("t1 c0 bus_cyc", 64'(bus_cyc), 64'd0);
    next_cycle(); look();                                              // c1
    cmp("t1 c1 bus_cyc", 64'(bus_cyc), 64'd1);
    cmp("t1 c1 bus_sel", 64'(bus_sel), 64'hF);
    next_cycle(); bus_ack = 1; bus_rdata = 32'h3C01_0001; look();      // c2
    cmp("t1 c2 stall_if", 64'(stallreq_from_if), 64'd1);
    next_cycle(); bus_ack = 0; bus_rdata = 0; look();                  // c3
    cmp("t1 c3 if_ready", 64'(if_ready), 64'd1);
    cmp("t1 c3 if_rdata", 64'(if_rdata), 64'h3C01_0001);
    cmp("t1 c3 stall_if", 64'(stallreq_from_if), 64'd0);
    next_cycle(); if_req = 0; look();                                  // c4
    cmp("t1 c4 bus_cyc", 64'(bus_cyc), 64'd0);
    next_cycle();

    // Contention: MEM load first, IF after the gap.
    if_req = 1; if_addr = 32'h200; mem_req = 1; mem_we = 0;            // c0
    mem_sel = 4'hF; mem_addr = 32'h80;
    next_cycle(); look();                                              // c1
    cmp("t2 c1 bus_addr", 64'(bus_addr), 64'h80);
    bus_ack = 1; bus_rdata = 32'h1111_2222;
    next_cycle(); bus_ack = 0; look();                                 // c2
    cmp("t2 c2 mem_ready", 64'(mem_ready), 64'd1);
    cmp("t2 c2 stall_if", 64'(stallreq_from_if), 64'd1);
    cmp("t2 c2 bus_cyc gap", 64'(bus_cyc), 64'd0);
    next_cycle(); mem_req = 0; look();                                 // c3
    cmp("t2 c3 bus_addr", 64'(bus_addr), 64'h200);
    bus_ack = 1; bus_rdata = 32'h3333_4444;
    next_cycle(); bus_ack = 0; look();                                 // c4
    cmp("t2 c4 if_rdata", 64'(if_rdata), 64'h3333_4444);
    next_cycle(); if_req = 0;
    next_cycle();

    // Store with ack after three wait cycles (ack on the watchdog's last cycle).
    mem_req = 1; mem_we = 1; mem_sel = 4'b0011; mem_wdata = 32'hDEAD_BEEF; mem_addr = 32'h40;
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      if (i == 4) begin bus_ack = 1; bus_rdata = 32'hFFFF_FFFF; end
      look();
      cmp("t3 bus_we", 64'(bus_we), 64'd1);
      cmp("t3 bus_sel", 64'(bus_sel), 64'h3);
    end
    next_cycle(); bus_ack = 0; bus_rdata = 0; look();                  // c5
    cmp("t3 mem_ready", 64'(mem_ready), 64'd1);
    cmp("t3 mem_rdata kept", 64'(mem_rdata), 64'h1111_2222);
    cmp("t3 timeout", 64'(timeout), 64'd0);
    next_cycle(); mem_req = 0; mem_we = 0; mem_sel = 0; mem_wdata = 0;
    next_cycle();

    // Flush at cycle 2 of a fetch, ack at cycle 4, new fetch from cycle 3.
    if_req = 1; if_addr = 32'h300;                                     // c0
    next_cycle();                                                      // c1
    next_cycle(); flush = 1;                                           // c2
    next_cycle(); flush = 0; if_addr = 32'h304; look();                // c3
    cmp("t4 c3 drain bus_cyc", 64'(bus_cyc), 64'd1);
    next_cycle(); bus_ack = 1; bus_rdata = 32'h5555_5555;              // c4
    next_cycle(); bus_ack = 0; look();                                 // c5
    cmp("t4 c5 if_ready", 64'(if_ready), 64'd0);
    cmp("t4 c5 bus_cyc", 64'(bus_cyc), 64'd0);
    next_cycle(); look();                                              // c6
    cmp("t4 c6 bus_addr", 64'(bus_addr), 64'h304);
    bus_ack = 1; bus_rdata = 32'h6666_6666;
    next_cycle(); bus_ack = 0; look();                                 // c7
    cmp("t4 c7 if_rdata", 64'(if_rdata), 64'h6666_6666);
    next_cycle(); if_req = 0;
    next_cycle();

    // Timeout on a load: bus_cyc for four cycles, then abort.
    mem_req = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h90;        // c0
    for (int i = 1; i <= 4; i++) next_cycle();                         // c1..c4
    next_cycle(); look();                                              // c5
    cmp("t5 timeout", 64'(timeout), 64'd1);
    cmp("t5 mem_ready", 64'(mem_ready), 64'd1);
    cmp("t5 mem_rdata", 64'(mem_rdata), 64'd0);
    cmp("t5 bus_cyc", 64'(bus_cyc), 64'd0);
    next_cycle(); mem_req = 0;
    next_cycle();

    // Timeout while draining a flushed fetch: no ready.
    if_req = 1; if_addr = 32'h400;                                     // c0
    next_cycle(); flush = 1;                                           // c1
    next_cycle(); flush = 0; if_req = 0;                               // c2
    next_cycle(); next_cycle(); next_cycle(); look();                  // c5
    cmp("t5b timeout", 64'(timeout), 64'd1);
    cmp("t5b if_ready", 64'(if_ready), 64'd0);
    next_cycle();

    // Asynchronous reset in the middle of BUS_MEM.
    mem_req = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'hA0;        // c0
    next_cycle(); look();                                              // c1
    cmp("t6 c1 bus_cyc", 64'(bus_cyc), 64'd1);
    next_cycle(); look(); rst = 0; #1;                                 // c2
    cmp("t6 async bus_cyc", 64'(bus_cyc), 64'd0);
    cmp("t6 async stall_mem", 64'(stallreq_from_mem), 64'd0);
    cmp("t6 async if_rdata", 64'(if_rdata), 64'd0);
    next_cycle(); rst = 1; look();                                     // r0
    cmp("t6 r0 stall_mem", 64'(stallreq_from_mem), 64'd1);
    next_cycle(); look();                                              // r1
    cmp("t6 r1 bus_addr", 64'(bus_addr), 64'hA0);
    bus_ack = 1; bus_rdata = 32'h7777_7777;
    next_cycle(); bus_ack = 0; look();                                 // r2
    cmp("t6 r2 mem_rdata", 64'(mem_rdata), 64'h7777_7777);
    next_cycle(); mem_req = 0;
    next_cycle(); next_cycle(); next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
